// File: rtl/pwm_line_feeder.sv
// Line feeder for the PWM channel array: buffers duty words in a FIFO and emits
// one STAGE-word burst per PWM period, aligned to the global counter period.
module pwm_line_feeder #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned STAGE      = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [DWIDTH-1:0]           in_data,
  output logic                        in_ready,
  output logic                        start,
  output logic [DWIDTH-1:0]           data,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 line_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(STAGE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   tmr_q, tmr_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                stop_q, stop_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                start_q, start_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         line_cnt_q, line_cnt_d;
  logic                push_c;
  logic                pop_c;
  logic [DWIDTH-1:0]   mem [FIFO_DEPTH];

  assign in_ready   = rst & (level_q < LW'(FIFO_DEPTH));
  assign push_c     = in_valid & in_ready;
  assign start      = start_q;
  assign data       = data_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign line_cnt   = line_cnt_q;

  // FIFO storage; writes are already blocked during reset through in_ready.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Next-state, burst sequencing and FIFO pointer logic.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bcnt_d     = bcnt_q;
    stop_d     = stop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    start_d    = 1'b0;
    data_d     = '0;
    underrun_d = 1'b0;
    line_cnt_d = line_cnt_q;
    pop_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_d  = '0;
        stop_d = 1'b0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        tmr_d = tmr_q + DWIDTH'(1);
        if (!en) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == '0) begin
          if (level_q >= LW'(STAGE)) begin
            pop_c      = 1'b1;
            start_d    = 1'b1;
            line_cnt_d = line_cnt_q + 16'd1;
            bcnt_d     = BW'(1);
            stop_d     = 1'b0;
            state_d    = (STAGE > 1) ? SEND : RUN;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      SEND: begin
        tmr_d  = tmr_q + DWIDTH'(1);
        pop_c  = 1'b1;
        bcnt_d = bcnt_q + BW'(1);
        if (!en) begin
          stop_d = 1'b1;
        end
        // Last word of the line: a dropped enable only takes effect here.
        if (bcnt_q == BW'(STAGE - 1)) begin
          bcnt_d = '0;
          if (stop_q || !en) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    if (pop_c) begin
      data_d   = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      bcnt_q     <= '0;
      stop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      start_q    <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bcnt_q     <= bcnt_d;
      stop_q     <= stop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      start_q    <= start_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      line_cnt_q <= line_cnt_d;
    end
  end

endmodule

// File: tb/tb_pwm_line_feeder.sv
// Directed bench for pwm_line_feeder (DWIDTH=4, STAGE=4, FIFO_DEPTH=8, period 16);
// pushed words go to a scoreboard queue and are popped as bursts appear.
module tb_pwm_line_feeder;

  localparam int unsigned DW = 4;
  localparam int unsigned ST = 4;
  localparam int unsigned FD = 8;
  localparam int unsigned LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          start;
  logic [DW-1:0] data;
  logic          underrun;
  logic [LW-1:0] fifo_level;
  logic [15:0]   line_cnt;

  int errors = 0;
  int checks = 0;
  int mlvl   = 0;
  int mlines = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  pwm_line_feeder #(
    .DWIDTH     (DW),
    .STAGE      (ST),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .data       (data),
    .underrun   (underrun),
    .fifo_level (fifo_level),
    .line_cnt   (line_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output logic [DW-1:0] w);
    if (sb.size() != 0) w = sb.pop_front();
    else w = '0;
  endtask

  // Cycles where neither a burst word nor an underrun may appear.
  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      cyc1();
      chk("quiet", 32'({start, underrun, data}), 32'h0);
    end
  endtask

  task automatic under();
    cyc1();
    chk("underrun", 32'({start, underrun, data}), 32'({1'b0, 1'b1, 4'h0}));
  endtask

  task automatic burst();
    logic [DW-1:0] w;
    for (int k = 0; k < ST; k++) begin
      cyc1();
      pop_exp(w);
      if (k == 0) mlines++;
      chk("burst_strobe", 32'({start, underrun}), 32'({(k == 0), 1'b0}));
      chk("burst_data", 32'(data), 32'(w));
    end
    mlvl -= int'(ST);
    chk("line_cnt", 32'(line_cnt), 32'(mlines));
  endtask

  task automatic push(input int v);
    logic acc;
    acc = (mlvl < int'(FD));
    in_valid = 1'b1;
    in_data  = DW'(v);
    chk("in_ready", 32'(in_ready), 32'(acc));
    cyc1();
    in_valid = 1'b0;
    if (acc) begin
      sb.push_back(DW'(v));
      mlvl++;
    end
    chk("push_quiet", 32'({start, underrun, data}), 32'h0);
  endtask

  initial begin
    logic [DW-1:0] w;
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    repeat (3) cyc1();
    chk("rst_outputs", 32'({start, underrun, data}), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_line_cnt", 32'(line_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    quiet(1);
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // basic burst
    for (int v = 1; v <= 4; v++) push(v);
    chk("t1_level_pre", 32'(fifo_level), 32'd4);
    en = 1'b1;
    quiet(1);
    burst();
    chk("t1_level_post", 32'(fifo_level), 32'd0);
    en = 1'b0;
    quiet(2);

    // period spacing then repeated underruns
    for (int v = 1; v <= 8; v++) push(v);
    en = 1'b1;
    quiet(1);
    burst();
    for (int v = 9; v <= 12; v++) push(v);
    quiet(8);
    burst();
    quiet(12);
    burst();
    quiet(12);
    under();
    quiet(15);
    under();
    en = 1'b0;
    quiet(2);

    // underrun at first slot, burst at the following slot
    for (int v = 13; v <= 15; v++) push(v);
    en = 1'b1;
    quiet(1);
    under();
    push(1);
    quiet(14);
    burst();
    en = 1'b0;
    quiet(2);

    // backpressure while disabled
    for (int v = 1; v <= 10; v++) push(v);
    chk("t4_level_full", 32'(fifo_level), 32'd8);
    chk("t4_ready_full", 32'(in_ready), 32'h0);
    en = 1'b1;
    quiet(1);
    cyc1();
    pop_exp(w);
    mlines++;
    chk("t4_start", 32'({start, data}), 32'({1'b1, w}));
    chk("t4_level_a", 32'(fifo_level), 32'd7);
    chk("t4_ready_a", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_data  = 4'hB;
    cyc1();
    in_valid = 1'b0;
    sb.push_back(4'hB);
    pop_exp(w);
    chk("t4_word1", 32'({start, data}), 32'({1'b0, w}));
    chk("t4_level_pushpop", 32'(fifo_level), 32'd7);
    for (int k = 2; k < int'(ST); k++) begin
      cyc1();
      pop_exp(w);
      chk("t4_word", 32'({start, data}), 32'({1'b0, w}));
    end
    mlvl = 5;
    chk("t4_level_b", 32'(fifo_level), 32'd5);
    quiet(12);
    burst();
    en = 1'b0;
    quiet(2);
    chk("t4_level_c", 32'(fifo_level), 32'd1);

    // enable drop at burst word 1: line completes, then nothing more
    for (int v = 12; v <= 15; v++) push(v);
    for (int v = 1; v <= 3; v++) push(v);
    en = 1'b1;
    quiet(1);
    for (int k = 0; k < int'(ST); k++) begin
      cyc1();
      pop_exp(w);
      if (k == 0) mlines++;
      chk("t5_word", 32'({start, underrun, data}), 32'({(k == 0), 1'b0, w}));
      if (k == 1) en = 1'b0;
    end
    mlvl -= int'(ST);
    quiet(40);
    chk("t5_level", 32'(fifo_level), 32'd4);
    chk("t5_line_cnt", 32'(line_cnt), 32'(mlines));

    // reset during word 2
    en = 1'b1;
    quiet(1);
    for (int k = 0; k < 3; k++) begin
      cyc1();
      pop_exp(w);
      chk("t6_word", 32'({start, data}), 32'({(k == 0), w}));
    end
    rst = 1'b0;
    en  = 1'b0;
    cyc1();
    chk("t6_rst_outputs", 32'({start, underrun, data}), 32'h0);
    chk("t6_rst_level", 32'(fifo_level), 32'h0);
    chk("t6_rst_line_cnt", 32'(line_cnt), 32'h0);
    chk("t6_rst_ready", 32'(in_ready), 32'h0);
    sb.delete();
    mlvl = 0;
    mlines = 0;
    rst = 1'b1;
    quiet(1);
    for (int v = 5; v <= 8; v++) push(v);
    en = 1'b1;
    quiet(1);
    burst();
    en = 1'b0;
    quiet(2);
    chk("t6_level_end", 32'(fifo_level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_line_feeder.md
# pwm_line_feeder

Upstream feeder for the PWM channel array. It buffers pixel duty values arriving on a valid/ready stream in a small FIFO. Once per PWM period it emits one line burst: a one-cycle `start` strobe with the first word, then the remaining STAGE-1 words on consecutive cycles. The burst feeds the data latch and shift-register chain directly. Bursts are spaced exactly one global-counter period (2**DWIDTH cycles) apart, so each latched line lines up with a full PWM cycle.

## Interface
- DWIDTH, 8, duty-value width; PWM period PERIOD = 2**DWIDTH cycles
- STAGE, 8, words per line (number of PWM channels); must be ≤ PERIOD
- FIFO_DEPTH, 16, input buffer depth; power of 2, ≥ STAGE
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  run enable
- in_valid  in  1  input word valid
- in_data  in  DWIDTH  input duty value
- in_ready  out  1  FIFO can accept a word
- start  out  1  line-start strobe, high with word 0 of a burst
- data  out  DWIDTH  line word to the latch
- underrun  out  1  one-cycle pulse: slot skipped due to insufficient data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- line_cnt  out  16  lines sent, wraps at 65535→0

## Operation
- FIFO write: `in_valid & in_ready` pushes `in_data`. `in_ready = rst & (fifo_level < FIFO_DEPTH)`.
- FIFO read: one pop per burst cycle. Push and pop in the same cycle are allowed and leave the level unchanged. Pop never happens when empty (guaranteed by the slot check).
- FSM states: IDLE, RUN, SEND. A period timer `tmr` counts 0..PERIOD-1.
  - IDLE: `tmr` is held at 0. If `en`=1, go to RUN with `tmr`=0.
  - RUN/SEND: `tmr` increments every cycle and wraps PERIOD-1→0.
  - Slot: a cycle in RUN with `tmr`==0.
    - If `fifo_level` ≥ STAGE, go to SEND.
    - Otherwise pulse `underrun` next cycle and stay in RUN. The next check is the next slot; there is no retry mid-period.
  - SEND: pops STAGE words over STAGE cycles. The burst counter runs 0..STAGE-1, then the FSM returns to RUN. `tmr` keeps running, so slots stay exactly PERIOD apart.
  - `en`=0 in RUN: go to IDLE next cycle.
  - `en`=0 in SEND: finish the burst, then go to IDLE. A partial line is never emitted.
- Outputs:
  - `start` is 1 only in the cycle that presents burst word 0.
  - `data` carries the popped word during a burst and is 0 otherwise.
  - `line_cnt` increments in the cycle `start` is high.
- Reset (rst=0 at an edge) applies even mid-burst:
  - FIFO is emptied, state goes to IDLE, `tmr` = 0.
  - `start`, `data`, `underrun`, `line_cnt`, `fifo_level` all go to 0.
  - Any burst in progress is aborted. No further word or `start` appears until a new slot after reset.

## Timing
- Slot detected at cycle T: `start`=1 and `data`=word0 at T+1; word k appears at T+1+k, for k < STAGE. All outputs are registered.
- Burst occupancy is T+1..T+STAGE. The next slot is at T+PERIOD, so the next `start` is at T+PERIOD+1.
- The `underrun` pulse appears at T+1 for a slot at T.
- `en` rising seen at edge E: the first slot is at E+1, so the earliest `start` is at E+2.
- Word order is strict FIFO order. Word 0 of a burst is the oldest word present at the slot.
- `fifo_level` updates the cycle after a push or pop. `in_ready` reflects the registered level, with no combinational path from `in_valid`.
- STAGE == PERIOD is legal: bursts are back-to-back with one `start` every PERIOD cycles.

## Test plan
- Basic burst (DWIDTH=4, STAGE=4, FIFO_DEPTH=8): push 0x1,0x2,0x3,0x4, then raise `en` → `start` pulses once with `data`=1, followed by 2,3,4 on consecutive cycles. `line_cnt`=1 and `fifo_level`=0.
- Period spacing: preload 12 words, `en`=1 → three `start` pulses exactly 16 cycles apart with data in order, then `underrun` pulses every 16 cycles.
- Underrun: preload 3 words, `en`=1 → `underrun` pulses at the first slot with no `start`. Push a 4th word → burst of 4 starts at the next slot, 16 cycles later.
- Full/backpressure: `en`=0, hold `in_valid`=1 → `in_ready` drops after 8 accepted words (`fifo_level`=8). Words 9+ are not accepted. A simultaneous push and pop during a burst leaves the level unchanged.
- `en` drop mid-burst: deassert `en` at burst word 1 → words 2,3 are still emitted, the FSM goes to IDLE, and no further `start` or `underrun` occurs.
- Reset mid-burst: drive `rst`=0 during word 2 → the next cycle has `start`=0, `data`=0, `fifo_level`=0, `line_cnt`=0. After release with `en`=1 and 4 words pushed, a clean burst starts at the next slot.
